// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the EX/MEM boundary.
// Holds the field widths of the EX/MEM payload and control words, the
// derived default widths, and the bit offsets used to pack/unpack the
// payload:  {bpc, alu_out, rd2, alu_zero, rd} (bpc in the MSBs)
// and the control word:  {ctlwb, ctlm} (ctlwb in the MSBs).
package pipe_pkg;

    localparam int PC_W   = 32;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int M_W    = 3;

    localparam int EX_MEM_DATA_W = PC_W + WORD_W + WORD_W + 1 + REG_W;
    localparam int EX_MEM_CTL_W  = WB_W + M_W;

    // Payload bit offsets (LSB position of each field).
    localparam int RD_LSB   = 0;
    localparam int ZERO_LSB = RD_LSB + REG_W;
    localparam int RD2_LSB  = ZERO_LSB + 1;
    localparam int ALU_LSB  = RD2_LSB + WORD_W;
    localparam int BPC_LSB  = ALU_LSB + WORD_W;

    // Control word bit offsets.
    localparam int M_LSB  = 0;
    localparam int WB_LSB = M_LSB + M_W;

    function automatic logic [EX_MEM_DATA_W-1:0] pack_payload(
        input logic [PC_W-1:0]   bpc,
        input logic [WORD_W-1:0] alu_out,
        input logic [WORD_W-1:0] rd2,
        input logic              alu_zero,
        input logic [REG_W-1:0]  rd
    );
        logic [EX_MEM_DATA_W-1:0] p;
        p = '0;
        p[BPC_LSB +: PC_W]    = bpc;
        p[ALU_LSB +: WORD_W]  = alu_out;
        p[RD2_LSB +: WORD_W]  = rd2;
        p[ZERO_LSB]           = alu_zero;
        p[RD_LSB +: REG_W]    = rd;
        return p;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline holding register: valid bit + control + payload.
// Ports:
//   clk, rst      : clock and synchronous active-high reset (clears everything)
//   load          : capture ld_ctl/ld_data and set valid (wins over clear)
//   clear         : drop valid; ctl/data keep their last value
//   ld_ctl, ld_data : value to capture
//   valid, ctl, data : registered contents
module pipe_entry #(
    parameter int DATA_W = 102,
    parameter int CTL_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTL_W-1:0]  ld_ctl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTL_W-1:0]  ctl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctl   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctl   <= ld_ctl;
            data  <= ld_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer.
// The main entry drives the MEM side; the skid entry catches the one
// instruction accepted while main is stalled, so in_ready can come straight
// from a register (NOT skid.valid) with no combinational path from out_ready.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : EX-side handshake; in_ctl/in_data its control/payload
//   flush               : drop both held entries at the next edge
//   out_valid/out_ready : MEM-side handshake; out_ctl/out_data its control/payload
//   occupancy           : registered count of held entries (0..2)
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = EX_MEM_DATA_W,
    parameter int CTL_W      = EX_MEM_CTL_W,
    parameter int BUBBLE_CTL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [CTL_W-1:0]  main_ctl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTL_W-1:0]  skid_ctl;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              consume;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [CTL_W-1:0]  main_src_ctl;
    logic [DATA_W-1:0] main_src_data;
    logic              main_next;
    logic              skid_next;
    logic [1:0]        occ_q;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign consume   = main_valid & out_ready;

    always_comb begin
        main_load     = 1'b0;
        main_clear    = flush | consume;
        skid_load     = 1'b0;
        skid_clear    = flush | (consume & skid_valid);
        main_src_ctl  = in_ctl;
        main_src_data = in_data;
        if (!flush) begin
            if (consume && skid_valid) begin
                // Skid drains into main; accept is impossible this cycle
                // because in_ready is low while skid is full.
                main_load     = 1'b1;
                main_src_ctl  = skid_ctl;
                main_src_data = skid_data;
            end else if (accept && (!main_valid || consume)) begin
                main_load = 1'b1;
            end else if (accept) begin
                // Main is full and stalled: park the new instruction.
                skid_load = 1'b1;
            end
        end
    end

    assign main_next = main_load | (main_valid & ~main_clear);
    assign skid_next = skid_load | (skid_valid & ~skid_clear);

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTL_W  (CTL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .ld_ctl  (main_src_ctl),
        .ld_data (main_src_data),
        .valid   (main_valid),
        .ctl     (main_ctl),
        .data    (main_data)
    );

    pipe_entry #(
        .DATA_W (DATA_W),
        .CTL_W  (CTL_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .ld_ctl  (in_ctl),
        .ld_data (in_data),
        .valid   (skid_valid),
        .ctl     (skid_ctl),
        .data    (skid_data)
    );

    // Occupancy is its own register, tracking the entries' next-state valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= {1'b0, main_next} + {1'b0, skid_next};
        end
    end

    assign occupancy = occ_q;
    assign out_data  = main_data;
    // A bubble must never carry write enables into MEM/WB.
    assign out_ctl   = ((BUBBLE_CTL != 0) && !main_valid) ? '0 : main_ctl;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the monitor keeps a queue of accepted
// instructions and compares every presented output against its head.
module tb_ex_mem_stage;
    import pipe_pkg::*;

    localparam int DW = EX_MEM_DATA_W;
    localparam int CW = EX_MEM_CTL_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    ex_mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctl    (in_ctl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctl   (out_ctl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic checking = 1'b0;

    logic [CW+DW-1:0] exp_q[$];   // held entries, head = main
    logic [DW-1:0]    seen[$];    // payloads delivered to MEM, in order
    logic [DW-1:0]    last_out;
    int               max_occ;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare visible state, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (checking) begin
            int n;
            n = exp_q.size();
            if (n > max_occ) max_occ = n;
            check("occupancy", 128'(occupancy), 128'(n));
            check("in_ready", 128'(in_ready), 128'(n < 2));
            check("out_valid", 128'(out_valid), 128'(n > 0));
            if (n > 0) begin
                check("out_data", 128'(out_data), 128'(exp_q[0][DW-1:0]));
                check("out_ctl", 128'(out_ctl), 128'(exp_q[0][CW+DW-1:DW]));
                last_out = exp_q[0][DW-1:0];
            end else begin
                check("bubble_ctl", 128'(out_ctl), 128'(0));
                check("hold_data", 128'(out_data), 128'(last_out));
            end
            if (rst) begin
                exp_q.delete();
                last_out = '0;
            end else if (flush) begin
                exp_q.delete();
            end else begin
                if (n > 0 && out_ready) begin
                    seen.push_back(exp_q[0][DW-1:0]);
                    void'(exp_q.pop_front());
                end
                if (in_valid && n < 2) exp_q.push_back({in_ctl, in_data});
            end
        end
    end

    // Drive one cycle of inputs just after the edge; also probe that
    // in_ready does not follow out_ready combinationally.
    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic rs);
        logic r0, r1;
        @(posedge clk);
        #1;
        in_valid = v; in_ctl = c; in_data = d; out_ready = ordy; flush = fl; rst = rs;
        #1 r0 = in_ready;
        out_ready = ~ordy;
        #1 r1 = in_ready;
        out_ready = ordy;
        if (checking) check("in_ready_comb", 128'(r1), 128'(r0));
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] pd;
        logic          saw_d;
        int            budget;
        rst = 1'b1; in_valid = 1'b1; in_ctl = 5'b11111; in_data = '1;
        flush = 1'b0; out_ready = 1'b1; last_out = '0; max_occ = 0;

        // Reset: two cycles with in_valid high.
        @(posedge clk); #1 checking = 1'b1;
        cyc(1'b1, 5'b11111, '1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_ctl", 128'(out_ctl), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_occupancy", 128'(occupancy), 128'(0));

        // Streaming: 8 back-to-back inputs, out_ready held high.
        seen.delete(); max_occ = 0;
        for (int i = 1; i <= 8; i++) cyc(1'b1, 5'b10110, DW'(i), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        check("stream_count", 128'(seen.size()), 128'(8));
        for (int i = 0; i < 8 && i < seen.size(); i++)
            check("stream_order", 128'(seen[i]), 128'(i + 1));
        check("stream_max_occ", 128'(max_occ), 128'(1));

        // Stall: A, B, C offered while out_ready is low.
        seen.delete();
        cyc(1'b1, 5'b00001, DW'('h0A), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b00010, DW'('h0B), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b00011, DW'('h0C), 1'b0, 1'b0, 1'b0);
        check("stall_occ", 128'(occupancy), 128'(2));
        check("stall_in_ready", 128'(in_ready), 128'(0));
        check("stall_main", 128'(out_data), 128'('h0A));
        check("stall_ctl", 128'(out_ctl), 128'(1));
        cyc(1'b1, 5'b00011, DW'('h0C), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'b00011, DW'('h0C), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        check("stall_count", 128'(seen.size()), 128'(3));
        if (seen.size() == 3) begin
            check("stall_out0", 128'(seen[0]), 128'('h0A));
            check("stall_out1", 128'(seen[1]), 128'('h0B));
            check("stall_out2", 128'(seen[2]), 128'('h0C));
        end

        // Flush with two held entries plus D, then with one held entry plus D.
        seen.delete(); saw_d = 1'b0;
        pd = pack_payload(32'h0000_0100, 32'hDDDD_0001, 32'h0, 1'b1, 5'd7);
        cyc(1'b1, 5'b00100, DW'('h21), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b00101, DW'('h22), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b11010, pd, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("flush2_out_valid", 128'(out_valid), 128'(0));
        check("flush2_out_ctl", 128'(out_ctl), 128'(0));
        check("flush2_occ", 128'(occupancy), 128'(0));
        check("flush2_in_ready", 128'(in_ready), 128'(1));
        cyc(1'b1, 5'b00110, DW'('h23), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b11010, pd, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("flush1_out_valid", 128'(out_valid), 128'(0));
        check("flush1_occ", 128'(occupancy), 128'(0));
        check("flush1_in_ready", 128'(in_ready), 128'(1));
        idle(4, 1'b1);
        for (int i = 0; i < seen.size(); i++) if (seen[i] == pd) saw_d = 1'b1;
        check("flush_d_dropped", 128'(saw_d), 128'(0));
        check("flush_nothing_out", 128'(seen.size()), 128'(0));

        // Reset mid-stall with two held entries (flush also high).
        seen.delete();
        cyc(1'b1, 5'b01001, DW'('h31), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b01010, DW'('h32), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'b01011, DW'('h33), 1'b1, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("rstmid_out_valid", 128'(out_valid), 128'(0));
        check("rstmid_out_data", 128'(out_data), 128'(0));
        check("rstmid_occ", 128'(occupancy), 128'(0));
        check("rstmid_in_ready", 128'(in_ready), 128'(1));
        idle(4, 1'b1);
        check("rstmid_no_emit", 128'(seen.size()), 128'(0));

        // Random traffic: 50% in_valid / out_ready.
        for (int i = 0; i < 10000; i++) begin
            logic [DW-1:0] rd;
            rd = {$urandom, $urandom, $urandom, $urandom};
            cyc(1'($urandom_range(0, 1)), CW'($urandom), rd,
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            idle(1, 1'b1);
            budget++;
        end
        check("random_drain", 128'(exp_q.size()), 128'(0));
        idle(2, 1'b1);

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 102, the payload width (bpc 32 + alu_out 32 + rd2 32 + alu_zero 1 + rd 5).
REQ-002 The module SHALL have parameter CTL_W, default 5, the control width (ctlwb 2 + ctlm 3).
REQ-003 The module SHALL have parameter BUBBLE_CTL, default 1; when 1, out_ctl is forced to zero while out_valid=0.
REQ-004 The port list SHALL begin with clk (input, 1): the single clock; all state updates on its rising edge.
REQ-005 The second port SHALL be rst (input, 1): reset, synchronous and active-high.
REQ-006 in_valid (input, 1): the EX side presents a valid instruction.
REQ-007 in_ready (output, 1): the stage accepts the input this cycle.
REQ-008 in_ctl (input, CTL_W): EX control bits.
REQ-009 in_data (input, DATA_W): EX payload.
REQ-010 flush (input, 1): discard all held instructions.
REQ-011 out_valid (output, 1): the MEM-side instruction is valid.
REQ-012 out_ready (input, 1): the MEM side consumes the output this cycle.
REQ-013 out_ctl (output, CTL_W): MEM control bits.
REQ-014 out_data (output, DATA_W): MEM payload.
REQ-015 occupancy (output, 2): number of held entries, 0..2.

Function
REQ-016 Storage SHALL be two registered entries: main (drives the outputs) and skid; each entry holds a valid bit, ctl and data.
REQ-017 in_ready SHALL equal NOT skid.valid, taken directly from a register with no combinational path from out_ready.
REQ-018 Transfers SHALL occur on these conditions only:
- accept = in_valid AND in_ready.
- consume = out_valid AND out_ready.
REQ-019 On accept with main empty, or with main consumed in the same cycle and skid empty, the input SHALL load main; latency is 1 cycle.
REQ-020 On accept with main full and not consumed, the input SHALL load skid.
REQ-021 On consume with skid full, skid SHALL move to main and skid SHALL become empty in the same edge.
- Input is not accepted that cycle (in_ready=0).
REQ-022 Entries SHALL leave in acceptance order; no entry is lost or duplicated.
REQ-023 When flush=1, both valid bits SHALL clear at the next edge regardless of accept or consume.
- An input presented in the flush cycle is dropped.
- in_ready=1 on the following cycle.
REQ-024 Behaviour on flush AND rst SHALL be identical to rst alone.
REQ-025 out_data SHALL hold its last value when invalid.
REQ-026 When BUBBLE_CTL=1, out_ctl SHALL be 0 while out_valid=0, so no memory write or register write results from a bubble.
REQ-027 occupancy SHALL equal main.valid + skid.valid, registered.
REQ-028 When out_ready is held at 1, throughput SHALL be one instruction per cycle with zero bubbles.

Reset
REQ-029 On rst=1 at a rising edge, the following SHALL take effect from the next cycle:
- main.valid=0, skid.valid=0.
- out_valid=0, out_ctl=0, out_data=0.
- occupancy=0, in_ready=1.
REQ-030 Reset SHALL take priority over accept, consume and flush, including when asserted mid-stall with two entries held.
REQ-031 The block SHALL rely on no initial blocks for functional reset.

Structure
REQ-032 A shared package pipe_pkg SHALL hold:
- the field widths (PC_W=32, WORD_W=32, REG_W=5, WB_W=2, M_W=3);
- the derived defaults for DATA_W and CTL_W;
- the bit offsets used to pack and unpack the payload.
REQ-033 One sub-module pipe_entry (valid+ctl+data register with load and clear) SHALL be instantiated twice (main, skid).
REQ-034 All other logic SHALL be in ex_mem_stage.

Verification
REQ-035 Reset scenario: rst for 2 cycles with in_valid=1 -> out_valid=0, out_ctl=0, in_ready=1, occupancy=0.
REQ-036 Streaming scenario: out_ready=1, 8 back-to-back inputs with data=0x01..0x08, ctl=5'b10110 -> identical sequence at the output, each 1 cycle later, occupancy never exceeds 1.
REQ-037 Stall scenario: out_ready=0 for 3 cycles while inputs A, B, C are offered ->
- A in main, B in skid, occupancy=2, in_ready=0, C held off.
- After out_ready=1, outputs are A, B, C in order.
REQ-038 Flush scenario: flush with occupancy=2 plus a concurrent input D ->
- Next cycle out_valid=0, out_ctl=0, occupancy=0, in_ready=1.
- D never appears at the output.
REQ-039 Reset-mid-stall scenario: rst with occupancy=2 -> the reset state of REQ-029 next cycle, and no held entry is emitted afterwards.
REQ-040 Random scenario: random in_valid/out_ready at 50% for 10k cycles -> a scoreboard sees in-order, lossless delivery.
- out_ctl=0 whenever out_valid=0.
- in_ready never depends combinationally on out_ready.
